// File: rtl/mem_scan_pkg.sv
// mem_scan_pkg
// Shared types and constants for the memory extreme-value scanner and any
// other memory-scan blocks that reuse its tag pipeline.
package mem_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } scan_state_e;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Deepest memory read latency the tag pipeline is expected to cover.
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/scan_tag_pipe.sv
// scan_tag_pipe
// DEPTH-stage {valid, addr} delay line that travels alongside a synchronous
// memory read so the address of each returning word is known when it lands.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears every stage
//   in_vld   read issued this cycle
//   in_addr  address of the read issued this cycle
//   out_vld  tail valid: rd_data is meaningful this cycle
//   out_addr address belonging to the word currently on rd_data
//   busy_up  some read is still in flight ahead of the tail stage
module scan_tag_pipe
  import mem_scan_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy_up
);

  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] adr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) adr[i] <= '0;
    end else begin
      vld[0] <= in_vld;
      adr[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_vld  = vld[DEPTH-1];
  assign out_addr = adr[DEPTH-1];

  // Only stages ahead of the tail count: the tail word is consumed this cycle.
  always_comb begin
    busy_up = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) busy_up = busy_up | vld[i];
  end

endmodule

// File: rtl/mem_extreme_scan.sv
// mem_extreme_scan
// Scans a window of a synchronous-read memory and reports the minimum or
// maximum word together with the address where it first occurs.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only while ready
//   mode                0 = minimum, 1 = maximum (latched at start)
//   base_addr, len      window start and word count, len may be 0..2**ADDR_W
//   rd_en, rd_addr      memory read port, one address per cycle
//   rd_data             memory data, valid RD_LAT cycles after rd_en
//   ready               idle, accepts start
//   done, empty         one-cycle completion pulse; empty when len was 0
//   res_val, res_addr   result, held until the next done
//
// state  | meaning
// IDLE   | waiting for start, ready high
// ISSUE  | one read per cycle, address wraps modulo the memory depth
// DRAIN  | reads issued, waiting for in-flight words to be compared
// FINISH | publish accumulator, pulse done next edge
module mem_extreme_scan
  import mem_scan_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              done,
  output logic              empty,
  output logic [DATA_W-1:0] res_val,
  output logic [ADDR_W-1:0] res_addr
);

  scan_state_e state_q, state_d;

  logic              mode_q;
  logic              empty_q;
  logic              first_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W:0]   rem_q;
  logic [DATA_W-1:0] acc_q;
  logic [ADDR_W-1:0] acc_addr_q;

  logic              tail_vld;
  logic [ADDR_W-1:0] tail_addr;
  logic              busy_up;
  logic              better;
  logic              take;

  scan_tag_pipe #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_en),
    .in_addr  (rd_addr),
    .out_vld  (tail_vld),
    .out_addr (tail_addr),
    .busy_up  (busy_up)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = cur_q;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = (len == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
      end
      // Leaving while the last word sits in the tail lets its compare land
      // on the same edge that enters FINISH.
      DRAIN:   if (!busy_up) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strict compare keeps the earliest address on ties; the first word of a
  // scan always loads so an all-ones (or all-zero) window reports its base.
  assign better = (mode_q == MODE_MAX) ? (rd_data > acc_q) : (rd_data < acc_q);
  assign take   = tail_vld && (first_q || better);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_MIN;
      empty_q    <= 1'b0;
      first_q    <= 1'b0;
      cur_q      <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      acc_addr_q <= '0;
      done       <= 1'b0;
      empty      <= 1'b0;
      res_val    <= '0;
      res_addr   <= '0;
    end else begin
      done  <= 1'b0;
      empty <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            cur_q      <= base_addr;
            rem_q      <= len;
            empty_q    <= (len == '0);
            first_q    <= 1'b1;
            acc_q      <= (mode == MODE_MAX) ? '0 : '1;
            acc_addr_q <= base_addr;
          end
        end
        ISSUE: begin
          cur_q <= cur_q + ADDR_W'(1);
          rem_q <= rem_q - (ADDR_W+1)'(1);
        end
        FINISH: begin
          done  <= 1'b1;
          empty <= empty_q;
          if (!empty_q) begin
            res_val  <= acc_q;
            res_addr <= acc_addr_q;
          end
        end
        default: ;
      endcase
      if (take) begin
        acc_q      <= rd_data;
        acc_addr_q <= tail_addr;
        first_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_extreme_scan.sv
module tb_mem_extreme_scan;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] base;
  logic [AW:0]   len;

  logic          rd_en1, ready1, done1, empty1;
  logic [AW-1:0] rd_addr1, res_addr1;
  logic [DW-1:0] rd_data1, res_val1;

  logic          rd_en3, ready3, done3, empty3;
  logic [AW-1:0] rd_addr3, res_addr3;
  logic [DW-1:0] rd_data3, res_val3;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] p0, p1;

  mem_extreme_scan #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_addr(base), .len(len), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .ready(ready1), .done(done1), .empty(empty1),
    .res_val(res_val1), .res_addr(res_addr1)
  );

  mem_extreme_scan #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_addr(base), .len(len), .rd_en(rd_en3), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .ready(ready3), .done(done3), .empty(empty3),
    .res_val(res_val3), .res_addr(res_addr3)
  );

  // Synchronous memories with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    rd_data1 <= mem[rd_addr1];
    p0       <= mem[rd_addr3];
    p1       <= p0;
    rd_data3 <= p1;
  end

  int checks = 0;
  int errors = 0;
  int exp_val = 0;
  int exp_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Reference: extreme over the window, then first window position holding it.
  task automatic ref_scan(input bit md, input int b, input int n);
    int ext;
    ext = md ? 0 : 255;
    for (int i = 0; i < n; i++) begin
      int d;
      d = int'(mem[(b + i) % DEPTH]);
      if (md) ext = (d > ext) ? d : ext;
      else    ext = (d < ext) ? d : ext;
    end
    for (int i = n - 1; i >= 0; i--)
      if (int'(mem[(b + i) % DEPTH]) == ext) exp_addr = (b + i) % DEPTH;
    exp_val = ext;
  endtask

  task automatic run_scan(input bit md, input int b, input int n, input bit mid_pulse,
                          input string tag);
    int n1, n3, d1, d3, k1, k3, m1, m3;
    int q1 [$];
    int q3 [$];
    if (n > 0) ref_scan(md, b, n);
    k1 = (n == 0) ? 1 : n + 2;
    k3 = (n == 0) ? 1 : n + 4;
    n1 = -1; n3 = -1; d1 = 0; d3 = 0;
    @(negedge clk);
    mode  = md;
    base  = AW'(b);
    len   = (AW+1)'(n);
    start = 1'b1;
    for (int c = 0; c <= n + 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        mode  = 1'($urandom);
        base  = AW'($urandom);
        len   = (AW+1)'($urandom_range(0, DEPTH));
        chk({tag, "_busy1"}, 32'(ready1), 32'd0);
        chk({tag, "_busy3"}, 32'(ready3), 32'd0);
      end
      if (mid_pulse && n > 0 && c == n) start = 1'b1;
      if (mid_pulse && n > 0 && c == n + 1) start = 1'b0;
      if (rd_en1) q1.push_back(int'(rd_addr1));
      if (rd_en3) q3.push_back(int'(rd_addr3));
      if (done1) begin
        d1++;
        if (n1 < 0) n1 = c;
        chk({tag, "_empty1"}, 32'(empty1), 32'(n == 0));
        chk({tag, "_val1"},   32'(res_val1), 32'(exp_val));
        chk({tag, "_addr1"},  32'(res_addr1), 32'(exp_addr));
      end
      if (done3) begin
        d3++;
        if (n3 < 0) n3 = c;
        chk({tag, "_empty3"}, 32'(empty3), 32'(n == 0));
        chk({tag, "_val3"},   32'(res_val3), 32'(exp_val));
        chk({tag, "_addr3"},  32'(res_addr3), 32'(exp_addr));
      end
    end
    chk({tag, "_lat1"}, 32'(n1), 32'(k1));
    chk({tag, "_lat3"}, 32'(n3), 32'(k3));
    chk({tag, "_ndone1"}, 32'(d1), 32'd1);
    chk({tag, "_ndone3"}, 32'(d3), 32'd1);
    chk({tag, "_nrd1"}, 32'(q1.size()), 32'(n));
    chk({tag, "_nrd3"}, 32'(q3.size()), 32'(n));
    m1 = -1; m3 = -1;
    foreach (q1[i]) if (m1 < 0 && q1[i] != (b + i) % DEPTH) m1 = i;
    foreach (q3[i]) if (m3 < 0 && q3[i] != (b + i) % DEPTH) m3 = i;
    chk({tag, "_seq1"}, 32'(m1), 32'hFFFF_FFFF);
    chk({tag, "_seq3"}, 32'(m3), 32'hFFFF_FFFF);
    chk({tag, "_hold1"}, 32'(res_val1), 32'(exp_val));
    chk({tag, "_ready1"}, 32'(ready1), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready1"}, 32'(ready1), 32'd1);
    chk({tag, "_ready3"}, 32'(ready3), 32'd1);
    chk({tag, "_rden1"},  32'(rd_en1), 32'd0);
    chk({tag, "_rden3"},  32'(rd_en3), 32'd0);
    chk({tag, "_rdaddr1"}, 32'(rd_addr1), 32'd0);
    chk({tag, "_done1"},  32'(done1), 32'd0);
    chk({tag, "_done3"},  32'(done3), 32'd0);
    chk({tag, "_empty1"}, 32'(empty1), 32'd0);
    chk({tag, "_val1"},   32'(res_val1), 32'd0);
    chk({tag, "_addr1"},  32'(res_addr1), 32'd0);
    chk({tag, "_val3"},   32'(res_val3), 32'd0);
    chk({tag, "_addr3"},  32'(res_addr3), 32'd0);
  endtask

  initial begin
    int stray;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; base = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(255 - i);
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(1'b0, 0, 1024, 1'b0, "full_min");
    run_scan(1'b1, 100, 10, 1'b0, "max_win");

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd50;
    mem[1022] = 8'd3;
    mem[1] = 8'd3;
    run_scan(1'b0, 1020, 8, 1'b0, "wrap");

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
    run_scan(1'b0, 37, 16, 1'b0, "all_ff");
    run_scan(1'b1, 500, 0, 1'b0, "len0");

    // Reset in the middle of a scan abandons it silently.
    @(negedge clk);
    mode = 1'b0; base = '0; len = 11'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    @(negedge clk);
    chk_reset_outputs("rst_held");
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done1 || done3 || rd_en1 || rd_en3 || !ready1 || !ready3) stray++;
    end
    chk("rst_quiet", 32'(stray), 32'd0);
    exp_val = 0;
    exp_addr = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
    run_scan(1'b1, 900, 150, 1'b1, "post_rst");

    for (int r = 0; r < 20; r++) begin
      int n;
      int span;
      span = (r % 2 == 0) ? 15 : 255;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, span));
      n = $urandom_range(1, 300);
      if (r == 3) n = 0;
      if (r == 7) n = 1;
      if (r == 11) n = 1024;
      run_scan(1'($urandom), $urandom_range(0, DEPTH - 1), n, 1'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_extreme_scan.md
Name: mem_extreme_scan

Overview:
Parametrised successor to the single-purpose 8-bit/1K minimum finder. It scans a programmable window of a synchronous-read memory and returns the minimum or maximum value together with the address where that value first occurs. Memory read latency is configurable. The start/ready/done handshake is explicit. It sits between a control FSM and a RAM read port in the datapath.

Parameters:
DATA_W, 8, width of memory words and result value
ADDR_W, 10, memory address width; depth = 2**ADDR_W
RD_LAT, 1, cycles from rd_en/rd_addr to valid rd_data (1..4)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = find minimum, 1 = find maximum; latched at start
base_addr  in  ADDR_W  first address of the window; latched at start
len  in  ADDR_W+1  number of words to scan (0..2**ADDR_W); latched at start
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  memory read address
rd_data  in  DATA_W  memory data, valid RD_LAT cycles after rd_en
ready  out  1  high in IDLE; block accepts start
done  out  1  one-cycle pulse when results are updated
empty  out  1  high with done when len was 0
res_val  out  DATA_W  extreme value found
res_addr  out  ADDR_W  address of the first occurrence of res_val

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, rd_en=0, rd_addr=0, done=0, empty=0, res_val=0, res_addr=0, pipeline valid bits cleared. Any scan in progress is abandoned, with no done pulse.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: ready=1. If start=1, latch mode/base_addr/len and set ready=0.
  - len==0: go to FINISH and flag empty.
  - Otherwise: go to ISSUE. Load the accumulator with 2**DATA_W-1 (min) or 0 (max). Set remaining=len. Set cur=base_addr.
- ISSUE: rd_en=1, rd_addr=cur, one address per cycle. cur wraps mod 2**ADDR_W (base 1020, len 8 reads 1020..1023,0..3). Decrement remaining. On the cycle remaining==1 is issued, go to DRAIN.
- Tag pipeline: RD_LAT-deep shift of {valid, addr} alongside memory latency. The compare stage uses rd_data when the tail valid=1.
- Compare rule, unsigned:
  - min: update when rd_data < acc.
  - max: update when rd_data > acc.
  - Strict comparison, so ties keep the earliest scanned address.
  - The first valid word always updates acc/addr (a forced-load flag), so an all-ones memory still reports a correct address.
- DRAIN: rd_en=0. Wait until the pipeline is empty, then go to FINISH.
- FINISH: latch res_val/res_addr from acc (unchanged if empty). Assert done=1 for one cycle, with empty per the latched flag. Go to IDLE; ready=1 on the next cycle.
- Latency: done asserts len+RD_LAT+1 cycles after the start-sampling edge (len>0), or 1 cycle after (len==0).
- start outside IDLE is ignored. mode/base_addr/len changes mid-scan have no effect.
- res_val/res_addr hold their last values until the next done.
- Full depth: len=2**ADDR_W is legal; each address is read exactly once.

Decomposition:
- Package mem_scan_pkg:
  - state enum {IDLE, ISSUE, DRAIN, FINISH}
  - MODE_MIN=0, MODE_MAX=1
  - RD_LAT_MAX=4
- One natural sub-module: scan_tag_pipe. It is the RD_LAT-stage {valid, addr} delay line with async reset. It is reusable by other memory-scan blocks.

Test Plan:
- Memory = 255-i for i<1024 (mod 256), mode=0, base=0, len=1024, RD_LAT=1 -> res_val=0 at res_addr=255 (first occurrence), done at cycle 1026, empty=0.
- Same memory, mode=1, base=100, len=10 -> res_val=155, res_addr=100. rd_addr sequence 100..109, one per cycle.
- Wrap: mem[1022]=3, mem[1]=3, others 50, mode=0, base=1020, len=8 -> res_val=3, res_addr=1022. rd_addr sequence 1020..1023,0..3.
- All words 8'hFF, mode=0, len=16, RD_LAT=3 -> res_val=255, res_addr=base. done 16+3+1 cycles after start.
- len=0 -> done and empty pulse 1 cycle after start, no rd_en, res_val/res_addr unchanged.
- rst_n low for 1 cycle mid-ISSUE, and start pulsed during DRAIN -> immediate IDLE, ready=1, rd_en=0, outputs at reset values, no done. A later start runs a clean scan; start during DRAIN is ignored.
